// File: rtl/jpc_pkg.sv
// Shared types and constants for the JPC instruction fetch stage.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

package jpc_pkg;

  localparam int JPC_ADDR_W = `JPC_ADDRESS_WIDTH;
  localparam int JPC_DATA_W = 32;

  // Byte distance between consecutive sequential fetches.
  localparam int PC_INC = 4;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HALT
  } fetch_state_e;

  // One buffered fetch result as seen by decode.
  typedef struct packed {
    logic [JPC_DATA_W-1:0] instr;
    logic [JPC_ADDR_W-1:0] pc;
    logic                  err;
  } fetch_entry_t;

endpackage

// File: rtl/jpc_fetch_fifo.sv
// Small synchronous FIFO between fetch and decode. Supports a flush that
// empties it in one cycle, and a push together with a pop even when full.
module jpc_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Pointer and occupancy bookkeeping; flush discards everything, including a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/jpc_ifetch.sv
// Instruction fetch stage: sequences single-outstanding imem fetches from the
// PC register, buffers results toward decode, and steers the PC register.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

module jpc_ifetch #(
  parameter int ADDR_WIDTH = `JPC_ADDRESS_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2,
  parameter int PC_INC     = jpc_pkg::PC_INC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_I,
  output logic [ADDR_WIDTH-1:0] next_pc_O,
  output logic                  pc_en_O,
  input  logic                  redirect_I,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_I,
  output logic                  imem_req_valid_O,
  input  logic                  imem_req_ready_I,
  output logic [ADDR_WIDTH-1:0] imem_req_addr_O,
  input  logic                  imem_rsp_valid_I,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data_I,
  input  logic                  imem_rsp_err_I,
  output logic                  if_valid_O,
  input  logic                  if_ready_I,
  output logic [DATA_WIDTH-1:0] if_instr_O,
  output logic [ADDR_WIDTH-1:0] if_pc_O,
  output logic                  if_err_O
);

  import jpc_pkg::*;

  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;

  fetch_state_e          state_q;
  fetch_state_e          state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [ADDR_WIDTH-1:0] req_addr_d;
  logic                  kill_q;
  logic                  kill_d;

  logic                  push;
  logic [ENTRY_W-1:0]    push_data;
  logic [ENTRY_W-1:0]    head;
  logic                  fifo_valid;
  logic [CNT_W-1:0]      count;
  logic                  pop;
  logic [CNT_W-1:0]      count_after_pop;
  logic                  space_now;
  logic                  space_after_push;
  logic                  misaligned;
  logic [ADDR_WIDTH-1:0] seq_pc;

  assign pop              = fifo_valid && if_ready_I;
  assign count_after_pop  = count - CNT_W'(pop);
  assign space_now        = count_after_pop < CNT_W'(BUF_DEPTH);
  assign space_after_push = (count_after_pop + CNT_W'(1)) < CNT_W'(BUF_DEPTH);
  assign misaligned       = (req_addr_q[1:0] != 2'b00);
  assign seq_pc           = req_addr_q + ADDR_WIDTH'(PC_INC);

  // Sequencer state, latched fetch address and the "drain the pending request" flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
    end
  end

  // Next-state, imem handshake, FIFO push and PC steering; redirect overrides the normal flow.
  always_comb begin
    state_d          = state_q;
    req_addr_d       = req_addr_q;
    kill_d           = kill_q;
    pc_en_O          = 1'b0;
    next_pc_O        = '0;
    imem_req_valid_O = 1'b0;
    push             = 1'b0;
    push_data        = '0;

    case (state_q)
      IDLE: begin
        if (space_now) begin
          state_d    = REQ;
          req_addr_d = pc_I;
        end
      end
      REQ: begin
        if (misaligned) begin
          push      = 1'b1;
          push_data = {1'b1, req_addr_q, {DATA_WIDTH{1'b0}}};
          state_d   = HALT;
        end else begin
          imem_req_valid_O = 1'b1;
          if (imem_req_ready_I) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = DRAIN;
            end else begin
              pc_en_O   = 1'b1;
              next_pc_O = seq_pc;
              state_d   = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (imem_rsp_valid_I) begin
          push      = 1'b1;
          push_data = {imem_rsp_err_I, req_addr_q, imem_rsp_data_I};
          if (imem_rsp_err_I) begin
            state_d = HALT;
          end else if (space_after_push) begin
            state_d    = REQ;
            req_addr_d = pc_I;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (imem_rsp_valid_I) begin
          state_d    = REQ;
          req_addr_d = pc_I;
        end
      end
      HALT: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect_I) begin
      pc_en_O   = 1'b1;
      next_pc_O = redirect_pc_I;
      push      = 1'b0;
      case (state_q)
        REQ: begin
          if (misaligned) begin
            state_d    = REQ;
            req_addr_d = redirect_pc_I;
            kill_d     = 1'b0;
          end else if (imem_req_ready_I) begin
            state_d = DRAIN;
            kill_d  = 1'b0;
          end else begin
            state_d = REQ;
            kill_d  = 1'b1;
          end
        end
        WAIT, DRAIN: begin
          if (imem_rsp_valid_I) begin
            state_d    = REQ;
            req_addr_d = redirect_pc_I;
          end else begin
            state_d = DRAIN;
          end
          kill_d = 1'b0;
        end
        default: begin
          state_d    = REQ;
          req_addr_d = redirect_pc_I;
          kill_d     = 1'b0;
        end
      endcase
    end
  end

  jpc_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_I),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .head_o      (head),
    .count_o     (count)
  );

  assign imem_req_addr_O                  = req_addr_q;
  assign if_valid_O                       = fifo_valid;
  assign {if_err_O, if_pc_O, if_instr_O}  = head;

endmodule

// File: tb/tb_jpc_ifetch.sv
// Directed bench for jpc_ifetch with a PC register, an imem responder and a
// negedge monitor that logs requests, PC updates and consumed entries.
module tb_jpc_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcReg;
  logic [31:0] nextPc;
  logic        pcEn;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspErr;
  logic        ifValid;
  logic        ifReady;
  logic [31:0] ifInstr;
  logic [31:0] ifPc;
  logic        ifErr;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  int          rspLat;
  logic        errEn;
  logic [31:0] errAddr;
  logic        pend;
  int          delayCnt;
  logic [31:0] pendAddr;

  logic [31:0] reqLog[$];
  int          reqCycLog[$];
  logic [31:0] pcEnLog[$];
  logic [31:0] popPcLog[$];
  logic [31:0] popInstrLog[$];
  logic        popErrLog[$];

  always #5 clk = ~clk;

  jpc_ifetch dut (
    .clk              (clk),
    .rst              (rst),
    .pc_I             (pcReg),
    .next_pc_O        (nextPc),
    .pc_en_O          (pcEn),
    .redirect_I       (redirect),
    .redirect_pc_I    (redirectPc),
    .imem_req_valid_O (reqValid),
    .imem_req_ready_I (reqReady),
    .imem_req_addr_O  (reqAddr),
    .imem_rsp_valid_I (rspValid),
    .imem_rsp_data_I  (rspData),
    .imem_rsp_err_I   (rspErr),
    .if_valid_O       (ifValid),
    .if_ready_I       (ifReady),
    .if_instr_O       (ifInstr),
    .if_pc_O          (ifPc),
    .if_err_O         (ifErr)
  );

  // PC register driven by the fetch stage.
  always @(posedge clk or posedge rst) begin
    if (rst) pcReg <= '0;
    else if (pcEn) pcReg <= nextPc;
  end

  // Instruction memory: one response per accepted request after rspLat cycles; data is ~address.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0; delayCnt <= 0; pendAddr <= '0;
      rspValid <= 1'b0; rspData <= '0; rspErr <= 1'b0;
    end else begin
      rspValid <= 1'b0;
      rspErr   <= 1'b0;
      if (pend) begin
        if (delayCnt <= 1) begin
          rspValid <= 1'b1; rspData <= ~pendAddr;
          rspErr <= errEn && (pendAddr == errAddr); pend <= 1'b0;
        end else begin
          delayCnt <= delayCnt - 1;
        end
      end
      if (reqValid && reqReady) begin
        if (rspLat <= 1) begin
          rspValid <= 1'b1; rspData <= ~reqAddr; rspErr <= errEn && (reqAddr == errAddr);
        end else begin
          pend <= 1'b1; pendAddr <= reqAddr; delayCnt <= rspLat - 1;
        end
      end
    end
  end

  // Cycle counter for request spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Event logger, sampling mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (reqValid && reqReady) begin reqLog.push_back(reqAddr); reqCycLog.push_back(cyc); end
      if (pcEn) pcEnLog.push_back(nextPc);
      if (ifValid && ifReady) begin
        popPcLog.push_back(ifPc); popInstrLog.push_back(ifInstr); popErrLog.push_back(ifErr);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_logs();
    reqLog.delete(); reqCycLog.delete(); pcEnLog.delete();
    popPcLog.delete(); popInstrLog.delete(); popErrLog.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirectPc = '0; ifReady = 1'b1; reqReady = 1'b1;
    rspLat = 1; errEn = 1'b0; errAddr = '0;
    step(2);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_accept(input logic [31:0] addr, input string name);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (reqValid && reqReady && reqAddr == addr) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL %s: request %h never accepted, expected within 60 cycles", name, addr); end
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirectPc = '0; ifReady = 1'b1; reqReady = 1'b1;
    rspLat = 1; errEn = 1'b0; errAddr = '0;
    step(2);
    checks++; if (reqValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid: got %b, expected 0", reqValid); end
    checks++; if (reqAddr !== 32'h0) begin errors++; $display("[TB] FAIL rst_req_addr: got %h, expected 0", reqAddr); end
    checks++; if (ifValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_if_valid: got %b, expected 0", ifValid); end
    checks++; if (pcEn !== 1'b0) begin errors++; $display("[TB] FAIL rst_pc_en: got %b, expected 0", pcEn); end
    checks++; if (nextPc !== 32'h0) begin errors++; $display("[TB] FAIL rst_next_pc: got %h, expected 0", nextPc); end
    rst = 1'b0;
    checks++; if (reqValid !== 1'b0) begin errors++; $display("[TB] FAIL idle_req_valid: got %b, expected 0", reqValid); end
    step(1);
    checks++; if (reqValid !== 1'b1) begin errors++; $display("[TB] FAIL first_req_valid: got %b, expected 1", reqValid); end
    checks++; if (reqAddr !== 32'h0) begin errors++; $display("[TB] FAIL first_req_addr: got %h, expected 0", reqAddr); end
  endtask

  task automatic test_sequential();
    logic [31:0] expReq[3];
    logic [31:0] expPc[3];
    expReq = '{32'h0, 32'h4, 32'h8};
    expPc  = '{32'h4, 32'h8, 32'hC};
    do_reset();
    step(12);
    checks++;
    if (reqLog.size() < 3 || pcEnLog.size() < 3 || popPcLog.size() < 3) begin
      errors++; $display("[TB] FAIL seq_counts: got req=%0d pcen=%0d pop=%0d, expected >=3 each", reqLog.size(), pcEnLog.size(), popPcLog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (reqLog[i] !== expReq[i]) begin errors++; $display("[TB] FAIL seq_req%0d: got %h, expected %h", i, reqLog[i], expReq[i]); end
        checks++; if (pcEnLog[i] !== expPc[i]) begin errors++; $display("[TB] FAIL seq_next_pc%0d: got %h, expected %h", i, pcEnLog[i], expPc[i]); end
        checks++; if (popPcLog[i] !== expReq[i]) begin errors++; $display("[TB] FAIL seq_if_pc%0d: got %h, expected %h", i, popPcLog[i], expReq[i]); end
        checks++; if (popInstrLog[i] !== ~expReq[i]) begin errors++; $display("[TB] FAIL seq_instr%0d: got %h, expected %h", i, popInstrLog[i], ~expReq[i]); end
        checks++; if (popErrLog[i] !== 1'b0) begin errors++; $display("[TB] FAIL seq_err%0d: got %b, expected 0", i, popErrLog[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++; if (reqCycLog[i] - reqCycLog[i-1] !== 2) begin errors++; $display("[TB] FAIL seq_spacing%0d: got %0d cycles, expected 2", i, reqCycLog[i] - reqCycLog[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ifReady = 1'b0;
    step(12);
    checks++; if (reqLog.size() !== 2) begin errors++; $display("[TB] FAIL bp_req_count: got %0d, expected 2", reqLog.size()); end
    checks++; if (pcReg !== 32'h8) begin errors++; $display("[TB] FAIL bp_pc_stop: got %h, expected 00000008", pcReg); end
    checks++; if (reqValid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_req: got %b, expected 0", reqValid); end
    checks++; if (ifValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_if_valid: got %b, expected 1", ifValid); end
    checks++; if (ifPc !== 32'h0) begin errors++; $display("[TB] FAIL bp_if_pc_hold: got %h, expected 0", ifPc); end
    checks++; if (ifInstr !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL bp_if_instr_hold: got %h, expected ffffffff", ifInstr); end
    ifReady = 1'b1;
    step(12);
    checks++;
    if (reqLog.size() < 3 || popPcLog.size() < 3) begin
      errors++; $display("[TB] FAIL bp_resume_counts: got req=%0d pop=%0d, expected >=3", reqLog.size(), popPcLog.size());
    end else begin
      checks++; if (reqLog[2] !== 32'h8) begin errors++; $display("[TB] FAIL bp_resume_req: got %h, expected 00000008", reqLog[2]); end
      checks++; if (popPcLog[0] !== 32'h0) begin errors++; $display("[TB] FAIL bp_order0: got %h, expected 0", popPcLog[0]); end
      checks++; if (popPcLog[1] !== 32'h4) begin errors++; $display("[TB] FAIL bp_order1: got %h, expected 4", popPcLog[1]); end
      checks++; if (popPcLog[2] !== 32'h8) begin errors++; $display("[TB] FAIL bp_order2: got %h, expected 8", popPcLog[2]); end
    end
  endtask

  task automatic test_redirect_drain();
    int stale;
    do_reset();
    rspLat = 3;
    wait_accept(32'h8, "rd_wait_8");
    step(1);
    clear_logs();
    redirect = 1'b1; redirectPc = 32'h100;
    #1;
    checks++; if (pcEn !== 1'b1 || nextPc !== 32'h100) begin errors++; $display("[TB] FAIL rd_same_cycle: got en=%b pc=%h, expected en=1 pc=00000100", pcEn, nextPc); end
    step(1);
    redirect = 1'b0;
    step(20);
    stale = 0;
    foreach (popPcLog[i]) if (popPcLog[i] == 32'h8) stale++;
    checks++; if (stale !== 0) begin errors++; $display("[TB] FAIL rd_drop_8: got %0d entries for 0x8, expected 0", stale); end
    checks++;
    if (reqLog.size() < 1 || pcEnLog.size() < 2 || popPcLog.size() < 1) begin
      errors++; $display("[TB] FAIL rd_counts: got req=%0d pcen=%0d pop=%0d, expected >=1,>=2,>=1", reqLog.size(), pcEnLog.size(), popPcLog.size());
    end else begin
      checks++; if (reqLog[0] !== 32'h100) begin errors++; $display("[TB] FAIL rd_next_req: got %h, expected 00000100", reqLog[0]); end
      checks++; if (pcEnLog[1] !== 32'h104) begin errors++; $display("[TB] FAIL rd_next_pc: got %h, expected 00000104", pcEnLog[1]); end
      checks++; if (popPcLog[0] !== 32'h100) begin errors++; $display("[TB] FAIL rd_first_pop: got %h, expected 00000100", popPcLog[0]); end
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    ifReady = 1'b0;
    redirect = 1'b1; redirectPc = 32'h102;
    step(1);
    redirect = 1'b0;
    checks++; if (reqValid !== 1'b0) begin errors++; $display("[TB] FAIL mis_no_req: got %b, expected 0", reqValid); end
    step(6);
    checks++; if (reqLog.size() !== 0) begin errors++; $display("[TB] FAIL mis_req_count: got %0d, expected 0", reqLog.size()); end
    checks++; if (ifValid !== 1'b1) begin errors++; $display("[TB] FAIL mis_if_valid: got %b, expected 1", ifValid); end
    checks++; if (ifPc !== 32'h102) begin errors++; $display("[TB] FAIL mis_if_pc: got %h, expected 00000102", ifPc); end
    checks++; if (ifErr !== 1'b1) begin errors++; $display("[TB] FAIL mis_if_err: got %b, expected 1", ifErr); end
    checks++; if (ifInstr !== 32'h0) begin errors++; $display("[TB] FAIL mis_if_instr: got %h, expected 0", ifInstr); end
    checks++; if (pcEnLog.size() !== 1) begin errors++; $display("[TB] FAIL mis_pc_updates: got %0d, expected 1", pcEnLog.size()); end
    clear_logs();
    redirect = 1'b1; redirectPc = 32'h200;
    step(1);
    redirect = 1'b0;
    checks++; if (ifValid !== 1'b0) begin errors++; $display("[TB] FAIL mis_flush: got %b, expected 0", ifValid); end
    ifReady = 1'b1;
    step(8);
    checks++;
    if (reqLog.size() < 1 || pcEnLog.size() < 2 || popPcLog.size() < 1) begin
      errors++; $display("[TB] FAIL mis_resume_counts: got req=%0d pcen=%0d pop=%0d, expected >=1,>=2,>=1", reqLog.size(), pcEnLog.size(), popPcLog.size());
    end else begin
      checks++; if (reqLog[0] !== 32'h200) begin errors++; $display("[TB] FAIL mis_resume_req: got %h, expected 00000200", reqLog[0]); end
      checks++; if (pcEnLog[1] !== 32'h204) begin errors++; $display("[TB] FAIL mis_resume_pc: got %h, expected 00000204", pcEnLog[1]); end
      checks++; if (popInstrLog[0] !== 32'hFFFFFDFF) begin errors++; $display("[TB] FAIL mis_resume_instr: got %h, expected fffffdff", popInstrLog[0]); end
    end
  endtask

  task automatic test_bus_error();
    do_reset();
    errEn = 1'b1; errAddr = 32'h10;
    step(20);
    checks++; if (reqLog.size() !== 5) begin errors++; $display("[TB] FAIL be_req_count: got %0d, expected 5", reqLog.size()); end
    checks++; if (reqValid !== 1'b0) begin errors++; $display("[TB] FAIL be_halt_no_req: got %b, expected 0", reqValid); end
    checks++; if (pcReg !== 32'h14) begin errors++; $display("[TB] FAIL be_pc: got %h, expected 00000014", pcReg); end
    checks++;
    if (popPcLog.size() !== 5) begin
      errors++; $display("[TB] FAIL be_pop_count: got %0d, expected 5", popPcLog.size());
    end else begin
      checks++; if (popPcLog[4] !== 32'h10) begin errors++; $display("[TB] FAIL be_err_pc: got %h, expected 00000010", popPcLog[4]); end
      checks++; if (popErrLog[4] !== 1'b1) begin errors++; $display("[TB] FAIL be_err_flag: got %b, expected 1", popErrLog[4]); end
      checks++; if (popErrLog[3] !== 1'b0) begin errors++; $display("[TB] FAIL be_prev_flag: got %b, expected 0", popErrLog[3]); end
      checks++; if (popInstrLog[4] !== 32'hFFFFFFEF) begin errors++; $display("[TB] FAIL be_err_instr: got %h, expected ffffffef", popInstrLog[4]); end
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    redirect = 1'b1; redirectPc = 32'hFFFFFFFC;
    step(1);
    redirect = 1'b0;
    step(8);
    checks++;
    if (reqLog.size() < 2 || pcEnLog.size() < 2 || popPcLog.size() < 1) begin
      errors++; $display("[TB] FAIL wrap_counts: got req=%0d pcen=%0d pop=%0d, expected >=2,>=2,>=1", reqLog.size(), pcEnLog.size(), popPcLog.size());
    end else begin
      checks++; if (reqLog[0] !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL wrap_req: got %h, expected fffffffc", reqLog[0]); end
      checks++; if (pcEnLog[1] !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next_pc: got %h, expected 0", pcEnLog[1]); end
      checks++; if (reqLog[1] !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next_req: got %h, expected 0", reqLog[1]); end
      checks++; if (popPcLog[0] !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL wrap_pop: got %h, expected fffffffc", popPcLog[0]); end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ifReady = 1'b0; rspLat = 5;
    wait_accept(32'h4, "rmw_wait_4");
    step(1);
    checks++; if (reqAddr !== 32'h4 || ifValid !== 1'b1) begin errors++; $display("[TB] FAIL rmw_pre: got addr=%h valid=%b, expected addr=00000004 valid=1", reqAddr, ifValid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (reqValid !== 1'b0) begin errors++; $display("[TB] FAIL rmw_req_valid: got %b, expected 0", reqValid); end
    checks++; if (reqAddr !== 32'h0) begin errors++; $display("[TB] FAIL rmw_req_addr: got %h, expected 0", reqAddr); end
    checks++; if (ifValid !== 1'b0) begin errors++; $display("[TB] FAIL rmw_if_valid: got %b, expected 0", ifValid); end
    checks++; if (pcEn !== 1'b0 || nextPc !== 32'h0) begin errors++; $display("[TB] FAIL rmw_pc_out: got en=%b pc=%h, expected en=0 pc=0", pcEn, nextPc); end
    step(1);
    rst = 1'b0; rspLat = 1; ifReady = 1'b1;
    clear_logs();
    step(4);
    checks++;
    if (reqLog.size() < 1) begin
      errors++; $display("[TB] FAIL rmw_restart_count: got %0d, expected >=1", reqLog.size());
    end else begin
      checks++; if (reqLog[0] !== 32'h0) begin errors++; $display("[TB] FAIL rmw_restart_req: got %h, expected 0", reqLog[0]); end
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirectPc = '0; ifReady = 1'b1; reqReady = 1'b1;
    rspLat = 1; errEn = 1'b0; errAddr = '0;
    $display("[TB] starting jpc_ifetch bench");
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drain();
    test_misaligned();
    test_bus_error();
    test_wrap();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
